decode_regfile: RTL and testbench

- Parametrised successor to the single-function decode stage: register file plus decode source selection plus writeback.
- Registered decode outputs behind a valid/stall handshake.
- Sits between fetch and execute in the Y86-64 datapath.
- Accepts up to two writebacks per cycle (E and M ports); ports stay generic in width and register count.

---
 rtl/decode_regfile.sv | 119 +++++++++++
 tb/tb_decode_regfile.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register file with E/M writeback ports, source select and a registered
// valid/stall output stage. Define DECODE_RF_WB_BYPASS_EN to forward same-edge writebacks into the captured operands.
module decode_regfile #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter int RID_W    = 4,
    parameter int RSP_ID   = 4,
    parameter int RNONE    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [3:0]        icode,
    input  logic [RID_W-1:0]  rA,
    input  logic [RID_W-1:0]  rB,
    input  logic              wbE_en,
    input  logic [RID_W-1:0]  dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic              wbM_en,
    input  logic [RID_W-1:0]  dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              out_valid,
    output logic [RID_W-1:0]  srcA,
    output logic [RID_W-1:0]  srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              ins_err
);
    // Handshake: a decode is captured on every rising edge with stall=0, and out_valid then
    // mirrors in_valid from that edge; with stall=1 every output register holds its value.

    localparam logic [RID_W-1:0] RSP_ID_V = RID_W'(RSP_ID);
    localparam logic [RID_W-1:0] RNONE_V  = RID_W'(RNONE);
    localparam logic [RID_W:0]   NREGS_V  = (RID_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              out_valid_q;
    logic [RID_W-1:0]  src_a_q, src_b_q;
    logic [DATA_W-1:0] val_a_q, val_b_q;
    logic              ins_err_q;

    logic [RID_W-1:0]  src_a_d, src_b_d;
    logic [DATA_W-1:0] val_a_d, val_b_d;
    logic              ins_err_d;
    logic              we_e, we_m;

    assign we_e = wbE_en && ({1'b0, dstE} < NREGS_V);
    assign we_m = wbM_en && ({1'b0, dstM} < NREGS_V);

    // Illegal icodes fall through to the defaults, so their sources read as RNONE.
    always_comb begin
        src_a_d   = RNONE_V;
        src_b_d   = RNONE_V;
        ins_err_d = 1'b0;
        if (in_valid) begin
            case (icode)
                4'h2, 4'h4, 4'h6, 4'hA: src_a_d = rA;
                4'h9, 4'hB:             src_a_d = RSP_ID_V;
                default:                src_a_d = RNONE_V;
            endcase
            case (icode)
                4'h4, 4'h5, 4'h6:       src_b_d = rB;
                4'h8, 4'h9, 4'hA, 4'hB: src_b_d = RSP_ID_V;
                default:                src_b_d = RNONE_V;
            endcase
            ins_err_d = (icode > 4'hB);
        end
    end

    always_comb begin
        val_a_d = '0;
        val_b_d = '0;
        if ({1'b0, src_a_d} < NREGS_V) val_a_d = regs_q[src_a_d];
        if ({1'b0, src_b_d} < NREGS_V) val_b_d = regs_q[src_b_d];
`ifdef DECODE_RF_WB_BYPASS_EN
        // M is applied last so it wins over E, matching the register-file write order.
        if (we_e && (dstE == src_a_d)) val_a_d = valE;
        if (we_m && (dstM == src_a_d)) val_a_d = valM;
        if (we_e && (dstE == src_b_d)) val_b_d = valE;
        if (we_m && (dstM == src_b_d)) val_b_d = valM;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            if (we_e) regs_q[dstE] <= valE;
            if (we_m) regs_q[dstM] <= valM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            src_a_q     <= RNONE_V;
            src_b_q     <= RNONE_V;
            val_a_q     <= '0;
            val_b_q     <= '0;
            ins_err_q   <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= in_valid;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            val_a_q     <= val_a_d;
            val_b_q     <= val_b_d;
            ins_err_q   <= ins_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign srcA      = src_a_q;
    assign srcB      = src_b_q;
    assign valA      = val_a_q;
    assign valB      = val_b_q;
    assign ins_err   = ins_err_q;
endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: directed test-plan cases plus randomized traffic
// against an array-based reference model.
module tb_decode_regfile;
    localparam int NR = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, stall;
    logic [3:0]  icode, rA, rB, dstE, dstM;
    logic        wbE_en, wbM_en;
    logic [63:0] valE, valM;
    logic        out_valid, ins_err;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB;

    decode_regfile dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .icode(icode),
        .rA(rA), .rB(rB), .wbE_en(wbE_en), .dstE(dstE), .valE(valE),
        .wbM_en(wbM_en), .dstM(dstM), .valM(valM), .out_valid(out_valid),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB), .ins_err(ins_err)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [63:0] m_regs [NR];
    logic        e_valid, e_err;
    logic [3:0]  e_sa, e_sb;
    logic [63:0] e_va, e_vb;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sel_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [3:0] sel_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [63:0] rd(input logic [63:0] r [NR], input logic [3:0] id);
        if (int'(id) < NR) return r[id];
        return 64'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 64'd0;
        e_valid = 1'b0; e_err = 1'b0; e_sa = 4'd15; e_sb = 4'd15; e_va = 64'd0; e_vb = 64'd0;
    endtask

    // One rising edge: reads see either the old file or the file after this edge's writes.
    task automatic model_edge();
        logic [63:0] pre [NR];
        logic [63:0] post [NR];
        pre = m_regs;
        post = m_regs;
        if (wbE_en && int'(dstE) < NR) post[dstE] = valE;
        if (wbM_en && int'(dstM) < NR) post[dstM] = valM;
        if (!stall) begin
            e_valid = in_valid;
            e_err   = in_valid && (icode > 4'hB);
            e_sa    = (in_valid && !e_err) ? sel_a(icode, rA) : 4'd15;
            e_sb    = (in_valid && !e_err) ? sel_b(icode, rB) : 4'd15;
`ifdef DECODE_RF_WB_BYPASS_EN
            e_va = rd(post, e_sa);
            e_vb = rd(post, e_sb);
`else
            e_va = rd(pre, e_sa);
            e_vb = rd(pre, e_sb);
`endif
        end
        m_regs = post;
    endtask

    // Scoreboard: compare every output against the model's current expectation.
    task automatic check_outputs();
        logic [63:0] ea, eb;
        exp_q.push_back(e_va);
        exp_q.push_back(e_vb);
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("srcA", 64'(srcA), 64'(e_sa));
        chk("srcB", 64'(srcB), 64'(e_sb));
        chk("ins_err", 64'(ins_err), 64'(e_err));
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        chk("valA", valA, ea);
        chk("valB", valB, eb);
    endtask

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; icode = 0; rA = 0; rB = 0;
        wbE_en = 0; dstE = 0; valE = 0; wbM_en = 0; dstM = 0; valM = 0;
    endtask

    task automatic decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        in_valid = 1; icode = ic; rA = ra; rB = rb;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #3;
        check_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        decode(4'h6, 4'd2, 4'd3);
        cycle();
        chk("t1_srcA", 64'(srcA), 64'd2);
        chk("t1_srcB", 64'(srcB), 64'd3);
        chk("t1_valA", valA, 64'd0);

        idle(); wbE_en = 1; dstE = 4'd2; valE = 64'h1234;
        cycle();
        idle(); decode(4'h4, 4'd2, 4'd2);
        cycle();
        chk("t2_valA", valA, 64'h1234);
        chk("t2_valB", valB, 64'h1234);

        idle(); wbE_en = 1; dstE = 4'd4; valE = 64'h100; wbM_en = 1; dstM = 4'd4; valM = 64'h200;
        cycle();
        idle(); decode(4'h9, 4'd0, 4'd0);
        cycle();
        chk("t3_srcA", 64'(srcA), 64'd4);
        chk("t3_valA", valA, 64'h200);
        chk("t3_valB", valB, 64'h200);

        idle(); decode(4'h5, 4'd0, 4'd5); wbE_en = 1; dstE = 4'd5; valE = 64'hAA;
        cycle();
`ifdef DECODE_RF_WB_BYPASS_EN
        chk("t4_valB", valB, 64'hAA);
`else
        chk("t4_valB", valB, 64'h0);
`endif

        idle(); decode(4'h6, 4'd2, 4'd3);
        cycle();
        stall = 1; decode(4'h2, 4'd5, 4'd5); wbE_en = 1; dstE = 4'd7; valE = 64'h77;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_stall_srcA", 64'(srcA), 64'd2);
            chk("t5_stall_valA", valA, 64'h1234);
            wbE_en = 0; icode = 4'(i + 8); rA = 4'(i);
        end
        idle(); decode(4'h6, 4'd7, 4'd7);
        cycle();
        chk("t5_after_valA", valA, 64'h77);

        idle(); decode(4'hD, 4'd1, 4'd1);
        cycle();
        chk("t6_err", 64'(ins_err), 64'd1);
        chk("t6_srcA", 64'(srcA), 64'd15);

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            stall    = 1'($urandom_range(0, 3) == 0);
            icode    = 4'($urandom_range(0, 15));
            rA       = 4'($urandom_range(0, 15));
            rB       = 4'($urandom_range(0, 15));
            wbE_en   = 1'($urandom_range(0, 1));
            dstE     = 4'($urandom_range(0, 15));
            valE     = {$urandom, $urandom};
            wbM_en   = 1'($urandom_range(0, 1));
            dstM     = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
            valM     = {$urandom, $urandom};
            cycle();
        end

        idle(); wbE_en = 1; dstE = 4'd2; valE = 64'h55;
        cycle();
        idle(); decode(4'h6, 4'd2, 4'd2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        wbE_en = 1; dstE = 4'd2; valE = 64'h99;
        cycle();
        rst = 1'b0;
        idle(); decode(4'h6, 4'd2, 4'd2);
        cycle();
        chk("t7_reg2", valA, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
